// File: rtl/sdcard_pkg.sv
// sdcard_pkg: shared state encoding and block geometry for the SD card RAM dumper
package sdcard_pkg;
  localparam int BLOCK_WORDS = 256;
  localparam int BLK_BITS = $clog2(BLOCK_WORDS);
  typedef enum logic [3:0] {
    INIT, IDLE, WRBLOCK, FETCH, WRL_0, WRL_1, WRH_0, WRH_1, NEXT, BLKEND, ERROR, DONE
  } state_t;
endpackage

// File: rtl/sdcard_dump_if.sv
// sdcard_dump_if: RAM read port and SD controller write port seen by the dumper
interface sdcard_dump_if;
  logic        ram_re;
  logic [24:0] ram_address;
  logic [15:0] ram_data;
  logic        ram_data_valid;
  logic        sd_wr;
  logic        sd_continue;
  logic [31:0] sd_addr;
  logic [7:0]  sd_data_o;
  logic        sd_busy;
  logic        sd_hndshk_o;
  logic        sd_hndshk_i;
  logic [15:0] sd_error;
  modport master (
    output ram_re, ram_address, sd_wr, sd_continue, sd_addr, sd_data_o, sd_hndshk_i,
    input  ram_data, ram_data_valid, sd_busy, sd_hndshk_o, sd_error
  );
  modport slave (
    input  ram_re, ram_address, sd_wr, sd_continue, sd_addr, sd_data_o, sd_hndshk_i,
    output ram_data, ram_data_valid, sd_busy, sd_hndshk_o, sd_error
  );
endinterface

// File: rtl/sdcard_dump.sv
// sdcard_dump: streams RAM words, low byte first, into consecutive SD blocks
module sdcard_dump
  import sdcard_pkg::*;
#(
  parameter logic [24:0] MAX_RAM_ADDRESS = 25'h3FFFFF,
  parameter bit          SDHC            = 1'b1
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic        start,
  sdcard_dump_if.master bus,
  output logic        dump_busy,
  output logic        dump_done,
  output logic        dump_error,
  output logic [19:0] hex_out
);
  state_t state, state_nx;
  logic [24:0] addr, addr_nx;
  logic [15:0] word, word_nx;
  logic [31:0] sd_addr;
  logic wr, cont, re, hs;

  always_ff @(posedge clk50 or negedge reset_n)
    if (!reset_n) begin
      state   <= INIT;
      addr    <= '0;
      word    <= '0;
      hex_out <= '0;
    end else begin
      state   <= state_nx;
      addr    <= addr_nx;
      word    <= word_nx;
      hex_out <= addr_nx[19:0];
    end

  assign sd_addr = SDHC ? {7'b0, addr} >> BLK_BITS : {6'b0, addr, 1'b0};

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    word_nx  = word;
    wr       = 1'b0;
    cont     = 1'b0;
    re       = 1'b0;
    hs       = 1'b0;
    case (state)
      INIT, BLKEND:
        if (!bus.sd_busy)
          state_nx = (bus.sd_error != '0) ? ERROR : (state == INIT ? IDLE : WRBLOCK);
      IDLE, DONE:
        if (start) begin
          state_nx = WRBLOCK;
          addr_nx  = '0;
        end
      WRBLOCK:
        if (addr >= MAX_RAM_ADDRESS) state_nx = DONE;
        else begin
          wr   = 1'b1;
          cont = sd_addr != '0;
          if (bus.sd_busy) state_nx = FETCH;
        end
      FETCH: begin
        re = 1'b1;
        if (bus.ram_data_valid) begin
          word_nx  = bus.ram_data;
          state_nx = WRL_0;
        end
      end
      WRL_0: if (bus.sd_hndshk_o) state_nx = WRL_1;
      WRL_1: begin
        hs = 1'b1;
        if (!bus.sd_hndshk_o) state_nx = WRH_0;
      end
      WRH_0: if (bus.sd_hndshk_o) state_nx = WRH_1;
      WRH_1: begin
        hs = 1'b1;
        if (!bus.sd_hndshk_o) state_nx = NEXT;
      end
      NEXT: begin
        addr_nx  = addr + 1'b1;
        state_nx = (addr_nx[BLK_BITS-1:0] == '0) ? BLKEND : FETCH;
      end
      default: ;
    endcase
  end

  // byte stays put through the whole handshake so the controller may sample late
  assign bus.sd_data_o   = (state == WRL_0 || state == WRL_1) ? word[7:0] :
                           (state == WRH_0 || state == WRH_1) ? word[15:8] : '0;
  assign bus.sd_addr     = sd_addr;
  assign bus.sd_wr       = wr;
  assign bus.sd_continue = cont;
  assign bus.ram_re      = re;
  assign bus.sd_hndshk_i = hs;
  assign bus.ram_address = addr;
  assign dump_busy       = state inside {WRBLOCK, FETCH, WRL_0, WRL_1, WRH_0, WRH_1, NEXT, BLKEND};
  assign dump_done       = state == DONE;
  assign dump_error      = state == ERROR;
endmodule

// File: tb/tb_sdcard_dump.sv
// tb_sdcard_dump: randomized RAM/SD controller models checked against the expected byte stream
module tb_sdcard_dump;
  import sdcard_pkg::*;
  localparam logic [24:0] MAX = 25'h1FF;
  localparam int NBLK = (int'(MAX) + BLOCK_WORDS - 1) / BLOCK_WORDS;
  localparam int NBYTES = NBLK * BLOCK_WORDS * 2;

  logic clk50 = 1'b0;
  logic reset_n, start;
  logic dump_busy, dump_done, dump_error, b2_busy, b2_done, b2_error;
  logic [19:0] hex_out, b2_hex;
  always #5 clk50 = ~clk50;

  sdcard_dump_if bus();
  sdcard_dump_if bus2();

  sdcard_dump #(.MAX_RAM_ADDRESS(MAX), .SDHC(1'b1)) dut (
    .clk50(clk50), .reset_n(reset_n), .start(start), .bus(bus.master),
    .dump_busy(dump_busy), .dump_done(dump_done), .dump_error(dump_error), .hex_out(hex_out)
  );
  sdcard_dump #(.MAX_RAM_ADDRESS(MAX), .SDHC(1'b0)) dut_byte (
    .clk50(clk50), .reset_n(reset_n), .start(start), .bus(bus2.master),
    .dump_busy(b2_busy), .dump_done(b2_done), .dump_error(b2_error), .hex_out(b2_hex)
  );
  assign bus2.ram_data       = bus.ram_data;
  assign bus2.ram_data_valid = bus.ram_data_valid;
  assign bus2.sd_busy        = bus.sd_busy;
  assign bus2.sd_hndshk_o    = bus.sd_hndshk_o;
  assign bus2.sd_error       = bus.sd_error;

  int checks = 0, failures = 0;
  int re_drop = 0, unstable = 0, words_read = 0;
  int ram_dly_max = 0, hs_max = 0;
  bit noise = 0, ram_fixed = 0;
  logic [15:0] mem [1024];
  logic [7:0]  bytes_q [$];
  logic [31:0] addr_q [$], addr2_q [$];
  logic        cont_q [$];

  task automatic ram_proc();
    int d;
    forever begin
      @(negedge clk50);
      bus.ram_data_valid = 1'b0;
      if (bus.ram_re) begin
        d = ram_fixed ? 5 : $urandom_range(0, ram_dly_max);
        repeat (d) begin
          @(negedge clk50);
          if (!bus.ram_re) re_drop++;
        end
        bus.ram_data = mem[bus.ram_address[9:0]];
        bus.ram_data_valid = 1'b1;
        words_read++;
      end else if (noise && $urandom_range(0, 3) == 0) begin
        bus.ram_data = 16'($urandom);
        bus.ram_data_valid = 1'b1;
      end
    end
  endtask

  task automatic sd_proc();
    logic [7:0] b;
    forever begin
      @(negedge clk50);
      if (bus.sd_wr) begin
        addr_q.push_back(bus.sd_addr);
        cont_q.push_back(bus.sd_continue);
        addr2_q.push_back(bus2.sd_addr);
        repeat ($urandom_range(0, 3)) @(negedge clk50);
        bus.sd_busy = 1'b1;
        for (int i = 0; i < 512; i++) begin
          repeat ($urandom_range(0, hs_max)) @(negedge clk50);
          bus.sd_hndshk_o = 1'b1;
          do @(negedge clk50); while (!bus.sd_hndshk_i);
          b = bus.sd_data_o;
          repeat ($urandom_range(0, hs_max)) begin
            @(negedge clk50);
            if (bus.sd_data_o !== b) unstable++;
          end
          bus.sd_hndshk_o = 1'b0;
          do @(negedge clk50); while (bus.sd_hndshk_i);
          bytes_q.push_back(b);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk50);
        bus.sd_busy = 1'b0;
      end
    end
  endtask

  // controller and RAM models restart from scratch whenever reset is applied
  initial begin
    bus.sd_busy = 1'b1;
    bus.sd_hndshk_o = 1'b0;
    bus.ram_data_valid = 1'b0;
    bus.ram_data = '0;
    forever begin
      @(posedge reset_n);
      repeat (5) @(negedge clk50);
      bus.sd_busy = 1'b0;
      fork
        ram_proc();
        sd_proc();
        @(negedge reset_n);
      join_any
      disable fork;
      bus.sd_busy = 1'b1;
      bus.sd_hndshk_o = 1'b0;
      bus.ram_data_valid = 1'b0;
    end
  end

  function automatic logic [91:0] outs();
    return {bus.ram_re, bus.sd_wr, bus.sd_continue, bus.sd_hndshk_i, dump_busy, dump_done,
            dump_error, bus.sd_data_o, bus.ram_address, bus.sd_addr, hex_out};
  endfunction

  function automatic int stream_errs();
    int e = (bytes_q.size() == NBYTES) ? 0 : 1;
    for (int i = 0; i < NBYTES && i < bytes_q.size(); i++) begin
      logic [15:0] w = mem[i / 2];
      if (bytes_q[i] !== ((i % 2) ? w[15:8] : w[7:0])) e++;
    end
    return e;
  endfunction

  function automatic int blk_errs();
    int e = (addr_q.size() == NBLK && addr2_q.size() == NBLK && cont_q.size() == NBLK) ? 0 : 1;
    for (int k = 0; k < NBLK && k < addr_q.size() && k < addr2_q.size() && k < cont_q.size(); k++)
      if (addr_q[k] !== 32'(k) || addr2_q[k] !== 32'(k * 512) || cont_q[k] !== (k != 0)) e++;
    return e;
  endfunction

  task automatic run_dump(input int stray_at, output bit to);
    int base = words_read;
    bit sent = 0;
    bytes_q.delete();
    addr_q.delete();
    addr2_q.delete();
    cont_q.delete();
    @(negedge clk50) start = 1'b1;
    @(negedge clk50) start = 1'b0;
    to = 1'b1;
    for (int n = 0; n < 40000; n++) begin
      if (dump_done) begin
        to = 1'b0;
        break;
      end
      @(negedge clk50);
      start = 1'b0;
      if (!sent && stray_at > 0 && words_read - base >= stray_at) begin
        start = 1'b1;
        sent = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk50);
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL reset_outs got=%h want=0", outs());
    end
    reset_n = 1'b1;
    repeat (15) @(negedge clk50);
    checks++;
    if ({dump_busy, dump_done, dump_error, bus.sd_wr} !== 4'b0000) begin
      failures++;
      $display("FAIL idle_status got=%b want=0000", {dump_busy, dump_done, dump_error, bus.sd_wr});
    end
  endtask

  task automatic test_dump_linear();
    bit to;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
    ram_fixed = 1'b1;
    hs_max = 0;
    run_dump(0, to);
    checks++;
    if (to) begin failures++; $display("FAIL linear_timeout got=timeout want=done"); end
    checks++;
    if (stream_errs() !== 0) begin
      failures++;
      $display("FAIL linear_stream errs=%0d size=%0d want errs=0 size=%0d", stream_errs(), bytes_q.size(), NBYTES);
    end
    checks++;
    if (blk_errs() !== 0) begin
      failures++;
      $display("FAIL linear_blocks errs=%0d want=0 (addr %p cont %p addr_byte %p)", blk_errs(), addr_q, cont_q, addr2_q);
    end
    checks++;
    if (bus.ram_address !== 25'h200 || hex_out !== 20'h200) begin
      failures++;
      $display("FAIL linear_final_addr got=%h/%h want=200/200", bus.ram_address, hex_out);
    end
    checks++;
    if ({dump_busy, dump_done, dump_error, bus.sd_wr} !== 4'b0100) begin
      failures++;
      $display("FAIL linear_done_status got=%b want=0100", {dump_busy, dump_done, dump_error, bus.sd_wr});
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hA55A;
    ram_fixed = 1'b0;
    ram_dly_max = 5;
    hs_max = 2;
    noise = 1'b1;
    run_dump(300, to);
    checks++;
    if (to) begin failures++; $display("FAIL b2b_timeout got=timeout want=done"); end
    checks++;
    if (bytes_q.size() < 2 || bytes_q[0] !== 8'h5A || bytes_q[1] !== 8'hA5) begin
      failures++;
      $display("FAIL byte_order got=%p want 5a,a5 first", bytes_q[0:1]);
    end
    checks++;
    if (stream_errs() !== 0) begin
      failures++;
      $display("FAIL b2b_stream errs=%0d size=%0d want errs=0 size=%0d", stream_errs(), bytes_q.size(), NBYTES);
    end
    checks++;
    if (blk_errs() !== 0) begin failures++; $display("FAIL b2b_blocks errs=%0d want=0", blk_errs()); end
    checks++;
    if (re_drop !== 0 || unstable !== 0) begin
      failures++;
      $display("FAIL hold_rules ram_re_drops=%0d data_changes=%0d want 0/0", re_drop, unstable);
    end
  endtask

  task automatic test_reset_midblock();
    bit to;
    int base = words_read;
    @(negedge clk50) start = 1'b1;
    @(negedge clk50) start = 1'b0;
    to = 1'b1;
    for (int n = 0; n < 20000; n++) begin
      if (words_read - base >= 100) begin to = 1'b0; break; end
      @(negedge clk50);
    end
    checks++;
    if (to) begin failures++; $display("FAIL mid_reach_timeout got=timeout want=word100"); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL async_reset_outs got=%h want=0", outs());
    end
    @(negedge clk50) reset_n = 1'b1;
    repeat (15) @(negedge clk50);
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    run_dump(0, to);
    checks++;
    if (to) begin failures++; $display("FAIL restart_timeout got=timeout want=done"); end
    checks++;
    if (stream_errs() !== 0 || blk_errs() !== 0) begin
      failures++;
      $display("FAIL restart_stream errs=%0d blk_errs=%0d want 0/0", stream_errs(), blk_errs());
    end
  endtask

  task automatic test_error();
    int base;
    bus.sd_error = 16'h0003;
    @(negedge clk50) reset_n = 1'b0;
    repeat (2) @(negedge clk50);
    reset_n = 1'b1;
    repeat (15) @(negedge clk50);
    checks++;
    if ({dump_busy, dump_done, dump_error} !== 3'b001) begin
      failures++;
      $display("FAIL init_error got=%b want=001", {dump_busy, dump_done, dump_error});
    end
    base = words_read;
    @(negedge clk50) start = 1'b1;
    @(negedge clk50) start = 1'b0;
    repeat (20) @(negedge clk50);
    checks++;
    if ({dump_busy, dump_done, dump_error, bus.sd_wr} !== 4'b0010 || words_read !== base) begin
      failures++;
      $display("FAIL error_sticky got=%b reads=%0d want=0010 reads=0",
               {dump_busy, dump_done, dump_error, bus.sd_wr}, words_read - base);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    bus.sd_error = '0;
    test_reset();
    test_dump_linear();
    test_back_to_back();
    test_reset_midblock();
    test_error();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sdcard_dump.md
SDCARD_DUMP -- requirements
Module: sdcard_dump

Interface
REQ-001 Parameter MAX_RAM_ADDRESS, default 25'h3FFFFF: last 16-bit word address dumped; the dump ends at the first block boundary at or above it.
REQ-002 Parameter SDHC, default 1'b1: 1 means the SD address is a block address (word address >> 8); 0 means it is a byte address (word address << 1).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk50  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle pulse; begins a dump from word address 0.
REQ-007 ram_re  out  1  RAM read request; held high until ram_data_valid.
REQ-008 ram_address  out  25  word address of the current RAM read.
REQ-009 ram_data  in  16  RAM read data; sampled in the cycle ram_data_valid is high.
REQ-010 ram_data_valid  in  1  RAM acknowledge that ram_data holds the requested word.
REQ-011 sd_wr  out  1  block-write request to the SD controller.
REQ-012 sd_continue  out  1  multi-block continue flag to the SD controller.
REQ-013 sd_addr  out  32  SD block/byte address, per SDHC.
REQ-014 sd_data_o  out  8  byte supplied to the SD controller.
REQ-015 sd_busy  in  1  SD controller busy.
REQ-016 sd_hndshk_o  in  1  controller requests a byte.
REQ-017 sd_hndshk_i  out  1  acknowledge that sd_data_o is valid.
REQ-018 sd_error  in  16  controller error code; 0 means no error.
REQ-019 dump_busy / dump_done / dump_error  out  1 each  status outputs.
REQ-020 hex_out  out  20  ram_address[19:0], registered, for the seven-segment display.

Function
REQ-021 The state machine SHALL have the states INIT, IDLE, WRBLOCK, FETCH, WRL_0, WRL_1, WRH_0, WRH_1, NEXT, BLKEND, ERROR and DONE.
REQ-022 INIT SHALL go to IDLE when sd_busy=0 and sd_error=0, and to ERROR when sd_busy=0 and sd_error!=0.
REQ-023 IDLE SHALL go to WRBLOCK on start, with the address cleared to 0.
REQ-024 WRBLOCK SHALL go to DONE when address >= MAX_RAM_ADDRESS; otherwise it SHALL assert sd_wr, and sd_continue when sd_addr!=0, and go to FETCH once sd_busy=1.
REQ-025 FETCH SHALL assert ram_re and, on ram_data_valid, latch ram_data and go to WRL_0.
REQ-026 WRL_0 SHALL drive sd_data_o = word[7:0] and go to WRL_1 when sd_hndshk_o=1.
REQ-027 WRL_1 SHALL hold sd_hndshk_i=1 and go to WRH_0 when sd_hndshk_o=0.
REQ-028 WRH_0 SHALL drive sd_data_o = word[15:8]; WRH_1 SHALL follow the same handshake as WRL_1 and then go to NEXT.
REQ-029 sd_data_o SHALL stay stable from WRx_0 until sd_hndshk_o falls in WRx_1.
REQ-030 NEXT SHALL increment the address by 1, then go to BLKEND if new address[7:0]==0, else to FETCH; each block is 256 words / 512 bytes.
REQ-031 BLKEND SHALL go to WRBLOCK when sd_busy=0 and sd_error=0, and to ERROR when sd_busy=0 and sd_error!=0.
REQ-032 ERROR SHALL be sticky (dump_error=1) and exit only on reset.
REQ-033 DONE SHALL set dump_done=1 and go to WRBLOCK at address 0 on start.
REQ-034 start SHALL be ignored in every state except IDLE and DONE.
REQ-035 ram_data_valid outside FETCH SHALL be ignored.
REQ-036 dump_busy SHALL be 1 in every state from WRBLOCK through BLKEND.
REQ-037 The address counter SHALL be 25 bits with no wrap: MAX_RAM_ADDRESS <= 25'h1FFFF00 is required.
REQ-038 sd_addr SHALL be combinational from the registered address.

Reset
REQ-039 Assertion of reset_n=0 SHALL, immediately and in any state (mid-block included), enter INIT with address=0, word=0, hex_out=0, and every output low (sd_addr follows address 0).
REQ-040 After reset the block SHALL NOT resume a partial block; the parent resets the SD controller with the same reset.

Structure
REQ-041 The state enumeration and the BLOCK_WORDS=256 constant SHALL reside in the shared package sdcard_pkg.
REQ-042 There SHALL be no sub-module; the parent instantiates SdCardCtrl and wires it to the sd_* ports.

Verification
REQ-043 MAX=25'h1FF, SDHC=1, RAM word n = n, start: 512 words written, sd_addr 0 then 1, sd_continue 0 then 1, dump_done=1.
REQ-044 Byte order: word 16'hA55A at address 0 -> first byte 8'h5A, second byte 8'hA5.
REQ-045 SDHC=0, second block: sd_addr = 32'h200.
REQ-046 sd_error=16'h0003 with sd_busy=0 in INIT -> ERROR; start has no effect; dump_error stays 1.
REQ-047 reset_n=0 at word 100 -> all outputs 0 asynchronously; after reinit and start, the dump restarts at address 0.
REQ-048 RAM valid delayed 5 cycles and sd_hndshk_o delayed randomly: ram_re is held the whole time, no byte is lost or duplicated, and bench count = 512*blocks.
